// File: rtl/pla_timer_compare_pkg.sv
// rtl/pla_timer_compare_pkg.sv - state codes, source/ALU select codes and control bundle
package pla_timer_compare_pkg;

    localparam int STATE_W_FIXED = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_LOAD_A = 4'b0001,
        ST_LOAD_B = 4'b0010,
        ST_SUB    = 4'b0011,
        ST_TEST   = 4'b0100,
        ST_MATCH  = 4'b0101,
        ST_MISS   = 4'b0110
    } state_e;

    // Register-file source select codes
    localparam logic [3:0] T_NONE  = 4'b0000;
    localparam logic [3:0] T_TIME  = 4'b0001;
    localparam logic [3:0] T_ALARM = 4'b0010;

    // ALU operation codes
    localparam logic [1:0] S_PASS = 2'b00;
    localparam logic [1:0] S_SUB  = 2'b01;

    // Full set of PLA outputs for one state
    typedef struct packed {
        logic [3:0] gout;
        logic [3:0] t;
        logic [1:0] s;
        logic       kc;
        logic       la;
        logic       lb;
        logic       ea;
        logic       lr;
        logic       er;
        logic       cc;
        logic       m;
    } ctrl_t;

endpackage

// File: rtl/pla_timer_compare_decode.sv
// rtl/pla_timer_compare_decode.sv - combinational PLA decode of state and flags
import pla_timer_compare_pkg::*;

module pla_timer_compare_decode (
    input  logic [3:0] gin,
    input  logic       Ts,
    input  logic       c7,
    input  logic       Az,
    output ctrl_t      ctrl
);

    // Decode current state and flags into next state and control strobes
    always_comb begin
        ctrl      = '0;
        ctrl.gout = ST_IDLE;
        ctrl.t    = T_NONE;
        ctrl.s    = S_PASS;
        case (gin)
            ST_IDLE: begin
                ctrl.cc   = 1'b1;
                ctrl.gout = Ts ? ST_LOAD_A : ST_IDLE;
            end
            ST_LOAD_A: begin
                ctrl.t    = T_TIME;
                ctrl.la   = 1'b1;
                ctrl.gout = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                ctrl.t    = T_ALARM;
                ctrl.lb   = 1'b1;
                ctrl.gout = ST_SUB;
            end
            ST_SUB: begin
                ctrl.ea   = 1'b1;
                ctrl.s    = S_SUB;
                ctrl.lr   = 1'b1;
                ctrl.gout = ST_TEST;
            end
            ST_TEST: begin
                ctrl.er = 1'b1;
                // A digit mismatch wins over the last-digit flag
                if (!Az) begin
                    ctrl.gout = ST_MISS;
                end else if (c7) begin
                    ctrl.gout = ST_MATCH;
                end else begin
                    ctrl.kc   = 1'b1;
                    ctrl.gout = ST_LOAD_A;
                end
            end
            ST_MATCH: begin
                ctrl.m    = 1'b1;
                ctrl.cc   = 1'b1;
                ctrl.gout = ST_IDLE;
            end
            ST_MISS: begin
                ctrl.cc   = 1'b1;
                ctrl.gout = ST_IDLE;
            end
            // Unused codes fall back to IDLE with all strobes quiet
            default: begin
                ctrl.gout = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pla_timer_compare.sv
// rtl/pla_timer_compare.sv - registered PLA controller for alarm-time digit compare
import pla_timer_compare_pkg::*;

module pla_timer_compare #(
    parameter int STATE_W = 4,
    parameter int SEL_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] gin,
    input  logic               Ts,
    input  logic               c7,
    input  logic               Az,
    output logic [STATE_W-1:0] gout,
    output logic [SEL_W-1:0]   T,
    output logic [1:0]         s,
    output logic               Kc,
    output logic               La,
    output logic               Lb,
    output logic               Ea,
    output logic               Lr,
    output logic               Er,
    output logic               Cc,
    output logic               M
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    pla_timer_compare_decode u_decode (
        .gin  (4'(gin)),
        .Ts   (Ts),
        .c7   (c7),
        .Az   (Az),
        .ctrl (ctrl_d)
    );

    // Output register: one-cycle latency, reset clears every output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign gout = STATE_W'(ctrl_q.gout);
    assign T    = SEL_W'(ctrl_q.t);
    assign s    = ctrl_q.s;
    assign Kc   = ctrl_q.kc;
    assign La   = ctrl_q.la;
    assign Lb   = ctrl_q.lb;
    assign Ea   = ctrl_q.ea;
    assign Lr   = ctrl_q.lr;
    assign Er   = ctrl_q.er;
    assign Cc   = ctrl_q.cc;
    assign M    = ctrl_q.m;

endmodule

// File: tb/tb_pla_timer_compare.sv
// tb/tb_pla_timer_compare.sv - self-checking bench for pla_timer_compare
module tb_pla_timer_compare;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gin;
    logic       Ts, c7, Az;
    logic [3:0] gout;
    logic [3:0] T;
    logic [1:0] s;
    logic       Kc, La, Lb, Ea, Lr, Er, Cc, M;

    int n_cmp = 0;
    int n_err = 0;

    pla_timer_compare #(.STATE_W(4), .SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .gin(gin), .Ts(Ts), .c7(c7), .Az(Az),
        .gout(gout), .T(T), .s(s), .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea),
        .Lr(Lr), .Er(Er), .Cc(Cc), .M(M)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] obs_vec();
        return {gout, T, s, Kc, La, Lb, Ea, Lr, Er, Cc, M};
    endfunction

    // Reference: what the controller must do in each state, written as rules
    function automatic logic [17:0] model(input int g, input bit ts, input bit lastd,
                                          input bit eq, input bit in_reset);
        int nxt = 0, tsel = 0, alu = 0;
        bit kc = 0, la = 0, lb = 0, ea = 0, lr = 0, er = 0, cc = 0, m = 0;
        if (!in_reset) begin
            if (g == 0) begin cc = 1; nxt = ts ? 1 : 0; end
            else if (g == 1) begin tsel = 1; la = 1; nxt = 2; end
            else if (g == 2) begin tsel = 2; lb = 1; nxt = 3; end
            else if (g == 3) begin ea = 1; alu = 1; lr = 1; nxt = 4; end
            else if (g == 4) begin
                er = 1;
                if (!eq) nxt = 6;
                else if (lastd) nxt = 5;
                else begin kc = 1; nxt = 1; end
            end
            else if (g == 5) begin m = 1; cc = 1; nxt = 0; end
            else if (g == 6) begin cc = 1; nxt = 0; end
        end
        return {4'(nxt), 4'(tsel), 2'(alu), kc, la, lb, ea, lr, er, cc, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed loop: feed gout back to gin, apply flags, check against the model
    task automatic run_cycle(input bit ts_v, input bit c7_v, input bit az_v, input string tag);
        logic [17:0] exp;
        gin = gout; Ts = ts_v; c7 = c7_v; Az = az_v;
        exp = model(int'(gin), Ts, c7, Az, !rst_n);
        tick();
        check(tag, 32'(obs_vec()), 32'(exp));
    endtask

    initial begin
        int kc_cnt, m_cnt;
        bit seen6, seen3;
        logic [17:0] exp;

        // Reset held with a busy state code on gin
        rst_n = 1'b0; gin = 4'b0011; Ts = 1'b1; c7 = 1'b0; Az = 1'b1;
        tick();
        check("reset_c1", 32'(obs_vec()), 32'h0);
        tick();
        check("reset_c2", 32'(obs_vec()), 32'h0);
        rst_n = 1'b1;

        // Idle wait with no alarm armed
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, "idle_vec");
            check("idle_gout", 32'(gout), 32'h0);
            check("idle_cc", 32'(Cc), 32'h1);
        end

        // Full seven-digit match
        kc_cnt = 0; m_cnt = 0;
        for (int i = 0; i < 80 && m_cnt == 0; i++) begin
            run_cycle(1'b1, kc_cnt == 6, 1'b1, "match_vec");
            if (Kc) kc_cnt++;
            if (M) begin
                m_cnt++;
                check("match_gout", 32'(gout), 32'h0);
            end
        end
        check("match_kc_pulses", 32'(kc_cnt), 32'd6);
        check("match_m_count", 32'(m_cnt), 32'd1);
        run_cycle(1'b0, 1'b0, 1'b1, "post_match_vec");
        check("match_m_one_cycle", 32'(M), 32'h0);
        check("post_match_idle", 32'(gout), 32'h0);

        // Mismatch at the first digit
        m_cnt = 0; seen6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0, "miss_vec");
            if (M) m_cnt++;
            if (seen6) begin
                check("miss_return", 32'(gout), 32'h0);
                break;
            end
            if (gout == 4'b0110) seen6 = 1'b1;
        end
        check("miss_seen", 32'(seen6), 32'h1);
        check("miss_no_m", 32'(m_cnt), 32'h0);

        // Illegal state code recovers to IDLE with all controls quiet
        gin = 4'b1010; Ts = 1'b1; c7 = 1'b1; Az = 1'b1;
        tick();
        check("illegal_1010", 32'(obs_vec()), 32'h0);

        // Reset while the compare sits in SUB
        gin = 4'b0000;
        tick();
        seen3 = 1'b0;
        for (int i = 0; i < 10 && !seen3; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1, "pre_sub_vec");
            if (gout == 4'b0011) seen3 = 1'b1;
        end
        check("reached_sub", 32'(seen3), 32'h1);
        gin = gout; rst_n = 1'b0;
        tick();
        check("reset_mid_vec", 32'(obs_vec()), 32'h0);
        check("reset_mid_no_m", 32'(M), 32'h0);
        rst_n = 1'b1;
        run_cycle(1'b0, 1'b0, 1'b0, "after_reset_vec");

        // Random open-loop stimulus against the model
        for (int i = 0; i < 400; i++) begin
            gin   = 4'($urandom_range(0, 15));
            Ts    = 1'($urandom);
            c7    = 1'($urandom);
            Az    = 1'($urandom);
            rst_n = ($urandom_range(0, 15) != 0);
            exp = model(int'(gin), Ts, c7, Az, !rst_n);
            tick();
            check("random_vec", 32'(obs_vec()), 32'(exp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pla_timer_compare.md
PLA_TIMER_COMPARE -- requirements
Module: pla_timer_compare

Interface
REQ-001 SHALL have parameter STATE_W, default 4, meaning state-code width; only 4 is supported.
REQ-002 SHALL have parameter SEL_W, default 4, meaning width of source-select output T.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port gin  input  4  current state code, fed back externally from gout.
REQ-006 SHALL have port Ts  input  1  timer-set flag; 1 means an alarm time is armed.
REQ-007 SHALL have port c7  input  1  digit counter terminal flag; 1 means the last (7th) digit is selected.
REQ-008 SHALL have port Az  input  1  ALU zero flag; 1 means the compared digits are equal.
REQ-009 SHALL have port gout  output  4  next state code.
REQ-010 SHALL have port T  output  4  register-file source select.
REQ-011 SHALL have port s  output  2  ALU operation select.
REQ-012 SHALL have ports Kc, La, Lb, Ea, Lr, Er  output  1 each: increment digit counter, load A, load B, enable A to ALU, load result, enable result.
REQ-013 SHALL have ports Cc  output  1  clear digit counter; M  output  1  alarm match pulse.

Function
REQ-014 SHALL register all outputs: on each rising clk edge with rst_n=1, outputs take the decode of the sampled gin/Ts/c7/Az; latency is exactly one cycle.
REQ-015 SHALL drive every control output to 0 and T=0, s=0 in any state where it is not listed below.
REQ-016 SHALL decode state IDLE (0000): Cc=1; gout=LOAD_A (0001) if Ts=1, else IDLE.
REQ-017 SHALL decode LOAD_A (0001): T=0001 (time digit), La=1; gout=LOAD_B (0010).
REQ-018 SHALL decode LOAD_B (0010): T=0010 (alarm digit), Lb=1; gout=SUB (0011).
REQ-019 SHALL decode SUB (0011): Ea=1, s=01 (subtract), Lr=1; gout=TEST (0100).
REQ-020 SHALL decode TEST (0100): Er=1; Az=0 gives gout=MISS (0110); Az=1 and c7=1 gives MATCH (0101); Az=1 and c7=0 gives Kc=1 and LOAD_A.
REQ-021 SHALL decode MATCH (0101): M=1, Cc=1; gout=IDLE.
REQ-022 SHALL decode MISS (0110): Cc=1; gout=IDLE.
REQ-023 SHALL treat Az as the priority input in TEST: a mismatch aborts regardless of c7.
REQ-024 SHALL ignore Ts in all states except IDLE; Ts falling mid-compare does not abort.
REQ-025 SHALL decode unused codes 0111-1111 as IDLE outputs with gout=IDLE (self-recovery).
REQ-026 SHALL assert M for exactly one cycle per full 7-digit match.

Reset
REQ-027 SHALL, on a rising clk edge with rst_n=0, set gout=0000, T=0000, s=00 and all 1-bit outputs to 0, overriding any decode.
REQ-028 SHALL resume decoding on the first rising edge with rst_n=1; reset mid-compare abandons the compare without asserting M.

Structure
REQ-029 SHALL place state encodings (IDLE..MISS), T source codes and s ALU codes in package pla_timer_compare_pkg.
REQ-030 SHALL implement the combinational PLA decode as sub-module pla_timer_compare_decode, with the output register in the top.

Verification
REQ-031 SHALL check reset: rst_n=0 for 2 cycles, gin=0011 -> all outputs 0, gout=0000.
REQ-032 SHALL check idle wait: gin loop, Ts=0 -> gout stays 0000, Cc=1 each cycle.
REQ-033 SHALL check full match: Ts=1, Az=1, c7=0 for 6 digit passes then c7=1 -> 6 Kc pulses, then M=1 one cycle, return to 0000.
REQ-034 SHALL check mismatch: Ts=1, Az=0 at first TEST -> gout=0110 then 0000, M never 1.
REQ-035 SHALL check illegal state: gin=1010 -> next gout=0000, all controls 0.
REQ-036 SHALL check reset mid-compare: rst_n=0 while in SUB -> outputs 0 next edge, no M.
